hdmi_channel_sequencer: RTL and testbench

HDMI_CHANNEL_SEQUENCER -- requirements
Module: hdmi_channel_sequencer

---
 rtl/hdmi_channel_sequencer.sv | 136 +++++++++++++
 tb/tb_hdmi_channel_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_channel_sequencer.sv
// ============================================================================
// hdmi_channel_sequencer: debounced next/prev buttons plus optional auto-cycle
// select one of four channels, committed only at frame boundaries.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hdmi_channel_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DWELL_FRAMES    = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       auto_en,
    input  logic       frame_start,
    output logic [1:0] channel_select,
    output logic       channel_changed,
    output logic       pending
);

    localparam logic [19:0] c_DB_LAST    = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  c_DWELL_LAST = 8'(DWELL_FRAMES - 1);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PENDING = 1'b1;

    logic [1:0] w_raw;
    logic [1:0] w_evt;

    assign w_raw = {btn_prev, btn_next};

    // Bit 0 = next, bit 1 = prev: synchroniser, debouncer and rising-edge detect.
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic        sync0_q;
        logic        sync1_q;
        logic        lvl_q;
        logic        lvl_prev_q;
        logic [19:0] cnt_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync0_q    <= 1'b0;
                sync1_q    <= 1'b0;
                lvl_q      <= 1'b0;
                lvl_prev_q <= 1'b0;
                cnt_q      <= 20'd0;
            end else begin
                sync0_q    <= w_raw[gi];
                sync1_q    <= sync0_q;
                lvl_prev_q <= lvl_q;
                if (sync1_q != lvl_q) begin
                    if (cnt_q == c_DB_LAST) begin
                        lvl_q <= sync1_q;
                        cnt_q <= 20'd0;
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end else begin
                    cnt_q <= 20'd0;
                end
            end
        end

        assign w_evt[gi] = lvl_q & ~lvl_prev_q;
    end

    logic       w_next_only;
    logic       w_prev_only;
    logic       w_any_press;

    assign w_next_only = w_evt[0] & ~w_evt[1];
    assign w_prev_only = w_evt[1] & ~w_evt[0];
    assign w_any_press = |w_evt;

    logic [0:0] state_q,   state_d;
    logic [1:0] target_q,  target_d;
    logic [1:0] chan_q,    chan_d;
    logic       changed_q, changed_d;
    logic [7:0] dwell_q,   dwell_d;

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        chan_d    = chan_q;
        changed_d = 1'b0;
        dwell_d   = dwell_q;

        // A press always wins the cycle, so a coincident frame boundary is skipped.
        if (w_next_only || w_prev_only) begin
            target_d = target_q + (w_next_only ? 2'd1 : 2'd3);
            state_d  = S_PENDING;
        end else if (state_q == S_PENDING && frame_start) begin
            chan_d    = target_q;
            changed_d = (target_q != chan_q);
            state_d   = S_IDLE;
        end else if (state_q == S_IDLE && auto_en && frame_start && !w_any_press) begin
            if (dwell_q == c_DWELL_LAST) begin
                chan_d    = chan_q + 2'd1;
                target_d  = chan_q + 2'd1;
                changed_d = 1'b1;
                dwell_d   = 8'd0;
            end else begin
                dwell_d = dwell_q + 8'd1;
            end
        end

        if (w_any_press || !auto_en) begin
            dwell_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            target_q  <= 2'd0;
            chan_q    <= 2'd0;
            changed_q <= 1'b0;
            dwell_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            chan_q    <= chan_d;
            changed_q <= changed_d;
            dwell_q   <= dwell_d;
        end
    end

    assign channel_select  = chan_q;
    assign channel_changed = changed_q;
    assign pending         = (state_q == S_PENDING);

endmodule

`default_nettype wire

// File: tb/tb_hdmi_channel_sequencer.sv
// ============================================================================
// tb_hdmi_channel_sequencer: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hdmi_channel_sequencer;

    localparam int DB = 4;
    localparam int DW = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       auto_en = 1'b0;
    logic       frame_start = 1'b0;
    logic [1:0] channel_select;
    logic       channel_changed;
    logic       pending;

    int n_checks = 0;
    int n_pass   = 0;

    hdmi_channel_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .DWELL_FRAMES   (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_next       (btn_next),
        .btn_prev       (btn_prev),
        .auto_en        (auto_en),
        .frame_start    (frame_start),
        .channel_select (channel_select),
        .channel_changed(channel_changed),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    // Behavioural model: index 0 = next button, 1 = prev button.
    int m_hist [2][2];
    int m_lvl  [2];
    int m_plvl [2];
    int m_run  [2];
    int m_raw  [2];
    int m_ch, m_tgt, m_pend, m_chg, m_dwell;
    bit evn, evp;

    always @(posedge clk) begin
        m_raw[0] = int'(btn_next);
        m_raw[1] = int'(btn_prev);
        evn = (m_lvl[0] == 1) && (m_plvl[0] == 0);
        evp = (m_lvl[1] == 1) && (m_plvl[1] == 0);
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                m_hist[b][0] = 0; m_hist[b][1] = 0;
                m_lvl[b] = 0; m_plvl[b] = 0; m_run[b] = 0;
            end
            m_ch = 0; m_tgt = 0; m_pend = 0; m_chg = 0; m_dwell = 0;
        end else begin
            m_chg = 0;
            if (evn != evp) begin
                m_tgt  = (m_tgt + (evn ? 1 : 3)) % 4;
                m_pend = 1;
            end else if (m_pend == 1 && frame_start) begin
                m_chg  = (m_tgt != m_ch) ? 1 : 0;
                m_ch   = m_tgt;
                m_pend = 0;
            end else if (m_pend == 0 && auto_en && frame_start && !(evn || evp)) begin
                if (m_dwell == DW - 1) begin
                    m_ch    = (m_ch + 1) % 4;
                    m_tgt   = m_ch;
                    m_chg   = 1;
                    m_dwell = 0;
                end else begin
                    m_dwell++;
                end
            end
            if (!auto_en || evn || evp) m_dwell = 0;
            for (int b = 0; b < 2; b++) begin
                m_plvl[b] = m_lvl[b];
                if (m_hist[b][1] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB) begin
                        m_lvl[b] = 1 - m_lvl[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_hist[b][1] = m_hist[b][0];
                m_hist[b][0] = m_raw[b];
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Debounced press followed by a debounced release; net one press event.
    task automatic press(input bit nxt);
        if (nxt) btn_next = 1'b1; else btn_prev = 1'b1;
        tick(8);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick(10);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_start = 1'b1; btn_next = 1'b1; auto_en = 1'b1;
        tick(3);
        n_checks++;
        if (channel_select !== 2'd0 || channel_changed !== 1'b0 || pending !== 1'b0)
            $display("FAIL reset_state got ch=%0d chg=%0b pend=%0b want 0/0/0",
                     channel_select, channel_changed, pending);
        else n_pass++;
        rst = 1'b0; frame_start = 1'b0; btn_next = 1'b0; auto_en = 1'b0;
        tick(12);
        do_reset();
    endtask

    task automatic test_debounce();
        btn_next = 1'b1;
        tick(3);
        btn_next = 1'b0;
        tick(10);
        n_checks++;
        if (pending !== 1'b0) $display("FAIL glitch_pending got %0b want 0", pending);
        else n_pass++;
        frame();
        n_checks++;
        if (channel_select !== 2'd0) $display("FAIL glitch_ch got %0d want 0", channel_select);
        else n_pass++;
        btn_next = 1'b1;
        tick(10);
        btn_next = 1'b0;
        tick(10);
        n_checks++;
        if (pending !== 1'b1 || channel_select !== 2'd0)
            $display("FAIL press_pending got pend=%0b ch=%0d want 1/0", pending, channel_select);
        else n_pass++;
        frame();
        n_checks++;
        if (channel_select !== 2'd1 || channel_changed !== 1'b1 || pending !== 1'b0)
            $display("FAIL press_commit got ch=%0d chg=%0b pend=%0b want 1/1/0",
                     channel_select, channel_changed, pending);
        else n_pass++;
        tick();
        n_checks++;
        if (channel_changed !== 1'b0) $display("FAIL changed_width got %0b want 0", channel_changed);
        else n_pass++;
    endtask

    task automatic test_accumulate();
        do_reset();
        press(1); press(1); press(1); press(0);
        frame();
        n_checks++;
        if (channel_select !== 2'd2 || channel_changed !== 1'b1)
            $display("FAIL accum_commit got ch=%0d chg=%0b want 2/1", channel_select, channel_changed);
        else n_pass++;
        press(1); frame();
        press(1); frame();
        n_checks++;
        if (channel_select !== 2'd0) $display("FAIL wrap_up got %0d want 0", channel_select);
        else n_pass++;
        press(0); frame();
        n_checks++;
        if (channel_select !== 2'd3) $display("FAIL wrap_down got %0d want 3", channel_select);
        else n_pass++;
    endtask

    task automatic test_coincident();
        // Raw high for 4 sampled edges; the press event lands in the cycle before edge 7.
        btn_next = 1'b1;
        tick(4);
        btn_next = 1'b0;
        tick(2);
        frame();
        n_checks++;
        if (channel_select !== 2'd3 || pending !== 1'b1)
            $display("FAIL coincide_hold got ch=%0d pend=%0b want 3/1", channel_select, pending);
        else n_pass++;
        tick(10);
        frame();
        n_checks++;
        if (channel_select !== 2'd0 || channel_changed !== 1'b1)
            $display("FAIL coincide_next got ch=%0d chg=%0b want 0/1", channel_select, channel_changed);
        else n_pass++;
    endtask

    task automatic test_auto();
        do_reset();
        press(0); frame();
        auto_en = 1'b1;
        tick();
        frame(); tick(2); frame(); tick(2);
        n_checks++;
        if (channel_select !== 2'd3) $display("FAIL auto_hold got %0d want 3", channel_select);
        else n_pass++;
        frame();
        n_checks++;
        if (channel_select !== 2'd0 || channel_changed !== 1'b1)
            $display("FAIL auto_adv1 got ch=%0d chg=%0b want 0/1", channel_select, channel_changed);
        else n_pass++;
        tick(2); frame(); tick(2); frame(); tick(2); frame();
        n_checks++;
        if (channel_select !== 2'd1) $display("FAIL auto_adv2 got %0d want 1", channel_select);
        else n_pass++;
        frame(); frame();
        press(1);
        frame();
        n_checks++;
        if (channel_select !== 2'd2 || pending !== 1'b0)
            $display("FAIL auto_manual got ch=%0d pend=%0b want 2/0", channel_select, pending);
        else n_pass++;
        frame(); frame();
        n_checks++;
        if (channel_select !== 2'd2) $display("FAIL auto_dwell_clr got %0d want 2", channel_select);
        else n_pass++;
        auto_en = 1'b0;
        tick();
        auto_en = 1'b1;
        frame(); frame();
        n_checks++;
        if (channel_select !== 2'd2) $display("FAIL auto_off_clr got %0d want 2", channel_select);
        else n_pass++;
        frame();
        n_checks++;
        if (channel_select !== 2'd3) $display("FAIL auto_after_clr got %0d want 3", channel_select);
        else n_pass++;
        auto_en = 1'b0;
        tick();
    endtask

    task automatic test_net_zero();
        press(1); press(0);
        n_checks++;
        if (pending !== 1'b1) $display("FAIL netzero_pend got %0b want 1", pending);
        else n_pass++;
        frame();
        n_checks++;
        if (channel_select !== 2'd3 || channel_changed !== 1'b0 || pending !== 1'b0)
            $display("FAIL netzero_commit got ch=%0d chg=%0b pend=%0b want 3/0/0",
                     channel_select, channel_changed, pending);
        else n_pass++;
    endtask

    task automatic test_reset_pending();
        do_reset();
        press(1); press(1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (channel_select !== 2'd0 || pending !== 1'b0)
            $display("FAIL rstpend got ch=%0d pend=%0b want 0/0", channel_select, pending);
        else n_pass++;
        frame();
        n_checks++;
        if (channel_select !== 2'd0 || channel_changed !== 1'b0)
            $display("FAIL rstpend_frame got ch=%0d chg=%0b want 0/0", channel_select, channel_changed);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) btn_next = ~btn_next;
            if ($urandom_range(0, 13) == 0) btn_prev = ~btn_prev;
            if ($urandom_range(0, 150) == 0) auto_en = ~auto_en;
            frame_start = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 700) == 0);
            tick();
            n_checks++;
            if (channel_select !== 2'(m_ch) || channel_changed !== 1'(m_chg) ||
                pending !== 1'(m_pend)) begin
                if (errs < 10)
                    $display("FAIL random_cyc%0d got ch=%0d chg=%0b pend=%0b want %0d/%0d/%0d",
                             i, channel_select, channel_changed, pending, m_ch, m_chg, m_pend);
                errs++;
            end else n_pass++;
        end
        rst = 1'b0; frame_start = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; auto_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_accumulate();
        test_coincident();
        test_auto();
        test_net_zero();
        test_reset_pending();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
